// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with registered result/flags, valid/ready on both
// sides, shifts, an iterative shift-add multiply and carry/overflow flags.
// Optional build macro: ALU_SIGNED_SLT_EN (SLT compares signed when defined,
// unsigned otherwise).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Operands are sampled only on an accepted input transfer; result and
// flags stay frozen while out_valid && !out_ready.
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_overflow;
  logic [2*WIDTH-1:0] r_ma;
  logic [WIDTH-1:0]   r_mb;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHW-1:0]     r_count;

  logic               w_accept;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic               w_lt;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_o;
  logic [2*WIDTH-1:0] w_acc_next;

  // Handshake outputs decoded from the registered state
  always_comb begin
    in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    out_valid = (r_state == S_DONE);
    w_accept  = in_valid && in_ready;
    result    = r_result;
    carry     = r_carry;
    overflow  = r_overflow;
    zero      = (r_result == '0);
    dbg_state = r_state;
  end

  // Single-cycle datapath for every opcode except MUL
  always_comb begin
    w_sum  = {1'b0, a} + {1'b0, b};
    w_diff = a - b;
`ifdef ALU_SIGNED_SLT_EN
    w_lt   = ($signed(a) < $signed(b));
`else
    w_lt   = (a < b);
`endif
    w_res  = '0;
    w_c    = 1'b0;
    w_o    = 1'b0;
    case (alu_control)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_o   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_c   = (a < b);
        w_o   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL: w_res = a << b[SHW-1:0];
      OP_SRL: w_res = a >> b[SHW-1:0];
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_lt};
      default: w_res = '0;
    endcase
  end

  // One shift-add step of the multiplier
  always_comb begin
    w_acc_next = r_mb[0] ? (r_acc + r_ma) : r_acc;
  end

  // Control FSM and all result/multiplier registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_ma       <= '0;
      r_mb       <= '0;
      r_acc      <= '0;
      r_count    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (alu_control == OP_MUL) begin
              r_ma    <= {{WIDTH{1'b0}}, a};
              r_mb    <= b;
              r_acc   <= '0;
              r_count <= '0;
              r_state <= S_MUL;
            end else begin
              r_result   <= w_res;
              r_carry    <= w_c;
              r_overflow <= w_o;
              r_state    <= S_DONE;
            end
          end else if ((r_state == S_DONE) && out_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_MUL: begin
          // Always runs all WIDTH iterations, even for zero operands
          r_acc   <= w_acc_next;
          r_ma    <= r_ma << 1;
          r_mb    <= r_mb >> 1;
          r_count <= r_count + SHW'(1);
          if (r_count == SHW'(WIDTH - 1)) begin
            r_result   <= w_acc_next[WIDTH-1:0];
            r_carry    <= |w_acc_next[2*WIDTH-1:WIDTH];
            r_overflow <= 1'b0;
            r_state    <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized checks of alu_mc (WIDTH=16) against an
// arithmetic reference model.
module tb_alu_mc;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   alu_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic [1:0]   dbg_state;

  int total;
  int bad;

  alu_mc #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .carry       (carry),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: results from plain integer arithmetic
  function automatic void model(input logic [2:0] op, input logic [W-1:0] xa,
                                input logic [W-1:0] xb, output logic [W-1:0] r,
                                output logic c, output logic o);
    longint ua, ub, sa, sb, full, sres, lim;
    ua  = longint'(xa);
    ub  = longint'(xb);
    sa  = longint'($signed(xa));
    sb  = longint'($signed(xb));
    lim = longint'(1) << W;
    r = '0;
    c = 1'b0;
    o = 1'b0;
    case (op)
      3'd0: begin
        full = ua + ub; r = W'(full); c = (full >= lim);
        sres = sa + sb; o = (sres >= (lim / 2)) || (sres < -(lim / 2));
      end
      3'd1: begin
        full = ua - ub; r = W'(full); c = (ua < ub);
        sres = sa - sb; o = (sres >= (lim / 2)) || (sres < -(lim / 2));
      end
      3'd2: r = W'(ua << (ub % W));
      3'd3: r = W'(ua >> (ub % W));
      3'd4: begin
        full = ua * ub; r = W'(full); c = (full >= lim);
      end
      3'd5: r = xa & xb;
      3'd6: r = xa | xb;
      default: begin
`ifdef ALU_SIGNED_SLT_EN
        r = (sa < sb) ? W'(1) : W'(0);
`else
        r = (ua < ub) ? W'(1) : W'(0);
`endif
      end
    endcase
  endfunction

  // One complete transaction with out_ready=1; checks exact latency and outputs
  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] xa,
                       input logic [W-1:0] xb, input logic [W-1:0] er,
                       input logic ec, input logic eo);
    int lat;
    lat = (op == 3'd4) ? W + 1 : 1;
    out_ready   = 1'b1;
    #1;
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    in_valid    = 1'b1;
    alu_control = op;
    a           = xa;
    b           = xb;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < lat; i++) tick();
    chk({tag, "_out_valid"}, W'(out_valid), W'(1));
    chk({tag, "_result"},    result,        er);
    chk({tag, "_carry"},     W'(carry),     W'(ec));
    chk({tag, "_overflow"},  W'(overflow),  W'(eo));
    chk({tag, "_zero"},      W'(zero),      W'(er == '0));
  endtask

  initial begin
    logic [W-1:0] er;
    logic         ec, eo;
    logic [2:0]   op;
    logic [W-1:0] ra, rb;
    total = 0;
    bad   = 0;

    // Reset for 2 cycles with a request present that must be ignored
    reset       = 1'b1;
    in_valid    = 1'b1;
    alu_control = 3'd0;
    a           = 16'h1234;
    b           = 16'h1111;
    out_ready   = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready",  W'(in_ready),  W'(1));
    chk("rst_result",    result,        W'(0));
    chk("rst_zero",      W'(zero),      W'(1));
    chk("rst_carry",     W'(carry),     W'(0));
    chk("rst_overflow",  W'(overflow),  W'(0));

    // ADD overflow, then back-to-back ADD with carry out
    in_valid = 1'b1; alu_control = 3'd0; a = 16'h7FFF; b = 16'h0001;
    tick();
    chk("add1_out_valid", W'(out_valid), W'(1));
    chk("add1_result",    result,        16'h8000);
    chk("add1_overflow",  W'(overflow),  W'(1));
    chk("add1_carry",     W'(carry),     W'(0));
    chk("add1_in_ready",  W'(in_ready),  W'(1));
    a = 16'hFFFF; b = 16'h0001;
    tick();
    chk("add2_out_valid", W'(out_valid), W'(1));
    chk("add2_result",    result,        16'h0000);
    chk("add2_zero",      W'(zero),      W'(1));
    chk("add2_carry",     W'(carry),     W'(1));
    chk("add2_overflow",  W'(overflow),  W'(0));
    in_valid = 1'b0;
    tick();
    chk("idle_out_valid", W'(out_valid), W'(0));

    // MUL timing: in_ready low for 16 cycles, out_valid at T+17
    in_valid = 1'b1; alu_control = 3'd4; a = 16'h0123; b = 16'h0045;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= W; i++) begin
      chk($sformatf("mul_busy_in_ready_%0d", i), W'(in_ready), W'(0));
      chk($sformatf("mul_busy_out_valid_%0d", i), W'(out_valid), W'(0));
      tick();
    end
    chk("mul1_out_valid", W'(out_valid), W'(1));
    chk("mul1_result",    result,        16'h4E6F);
    chk("mul1_carry",     W'(carry),     W'(0));
    tick();
    do_op("mul2", 3'd4, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0);
    do_op("mul_zero", 3'd4, 16'h0000, 16'hBEEF, 16'h0000, 1'b0, 1'b0);

    // Backpressure on SUB, competing OR request held off until out_ready rises
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; alu_control = 3'd1; a = 16'd5; b = 16'd7;
    tick();
    alu_control = 3'd6; a = 16'h00F0; b = 16'h000F;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_out_valid_%0d", i), W'(out_valid), W'(1));
      chk($sformatf("bp_result_%0d", i),    result,        16'hFFFE);
      chk($sformatf("bp_carry_%0d", i),     W'(carry),     W'(1));
      chk($sformatf("bp_overflow_%0d", i),  W'(overflow),  W'(0));
      chk($sformatf("bp_in_ready_%0d", i),  W'(in_ready),  W'(0));
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", W'(in_ready), W'(1));
    tick();
    in_valid = 1'b0;
    chk("or_out_valid", W'(out_valid), W'(1));
    chk("or_result",    result,        16'h00FF);
    chk("or_carry",     W'(carry),     W'(0));

    // SLT and shifts
`ifdef ALU_SIGNED_SLT_EN
    do_op("slt", 3'd7, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0);
`else
    do_op("slt", 3'd7, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0);
`endif
    do_op("sll", 3'd2, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0);
    do_op("srl", 3'd3, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0);

    // Reset 5 cycles after a MUL is accepted
    tick();
    in_valid = 1'b1; alu_control = 3'd4; a = 16'h0003; b = 16'h0005;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmul_out_valid", W'(out_valid), W'(0));
    chk("rmul_in_ready",  W'(in_ready),  W'(1));
    chk("rmul_result",    result,        W'(0));
    for (int i = 0; i < W + 4; i++) begin
      tick();
      chk($sformatf("rmul_quiet_%0d", i), W'(out_valid), W'(0));
    end
    do_op("post_rst_add", 3'd0, 16'd2, 16'd3, 16'd5, 1'b0, 1'b0);

    // Randomized operations against the reference model
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h8000;
        2:       ra = 16'h7FFF;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 16'h0000;
        1:       rb = 16'h0001;
        2:       rb = 16'h8000;
        default: rb = W'($urandom);
      endcase
      model(op, ra, rb, er, ec, eo);
      do_op($sformatf("rnd%0d_op%0d", n, op), op, ra, rb, er, ec, eo);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the processor's 16-bit combinational ALU.
- Adds registered operands and result, a valid/ready handshake on both sides, shifts, an iterative shift-add multiply, and carry/overflow flags.
- Sits between the decode/register-read stage and writeback. The pipeline stalls on in_ready / out_valid.

Parameters:
- WIDTH, 16, operand/result width in bits; a power of 2, minimum 4.
- SHW, $clog2(WIDTH), shift-amount width; local, not overridable.

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; low SHW bits are the shift amount for shifts
- alu_control  in  3  opcode
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- carry  out  1  carry/borrow/mul-overflow
- overflow  out  1  signed overflow (add/sub only, else 0)

Behaviour:
- Opcodes:
  - 000 ADD: a+b, carry = bit WIDTH.
  - 001 SUB: a-b, carry = borrow, i.e. a<b unsigned.
  - 010 SLL: a<<b[SHW-1:0].
  - 011 SRL: logical a>>b[SHW-1:0].
  - 100 MUL: low WIDTH bits of a*b unsigned; carry = 1 if the high half is nonzero.
  - 101 AND, 110 OR.
  - 111 SLT: result = 1 if a<b else 0; unsigned unless ALU_SIGNED_SLT_EN is defined.
- Flags:
  - carry = 0 for AND/OR/SLT/SLL/SRL.
  - overflow: ADD = (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]); SUB = (a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB]); otherwise 0.
  - zero is combinational from the result register.
- Handshake:
  - Transfer occurs when valid && ready are high on the same rising edge.
  - Inputs are sampled only on an accepted transfer.
  - result/flags are held stable while out_valid && !out_ready.
- FSM states IDLE, MUL, DONE:
  - IDLE: in_ready=1, out_valid=0. On accept of a non-MUL op, compute and register the result, then go to DONE. Latency is 1 cycle: out_valid is high the cycle after accept. On accept of MUL, latch a, b, clear the accumulator and set count=0, then go to MUL.
  - MUL: in_ready=0, out_valid=0. Each cycle: if mb[0] then acc += ma; ma <<= 1; mb >>= 1; count++. Use a 2*WIDTH accumulator. After exactly WIDTH iterations, register result/carry and go to DONE. MUL latency is WIDTH+1 cycles from accept to out_valid.
  - DONE: out_valid=1. in_ready = out_ready, giving back-to-back throughput of 1 op/cycle for non-MUL ops.
    - out_ready && in_valid: the new op is accepted in the same cycle. Non-MUL stays in DONE with the new result; MUL goes to MUL.
    - out_ready && !in_valid: go to IDLE.
    - !out_ready: hold everything.
- Boundaries:
  - Shift amounts use only b[SHW-1:0]; upper bits are ignored.
  - MUL with a=0 or b=0 still takes the full WIDTH iterations; there is no early termination.
  - An invalid/unused opcode is impossible (all 8 are defined).
  - in_valid dropping while in MUL has no effect.
- Reset:
  - Reset at any time, including mid-MUL, forces IDLE on the next edge.
  - result=0, carry=0, overflow=0, out_valid=0, in_ready=1 after reset; zero therefore reads 1.
  - Any in-flight MUL is discarded.
  - Requests presented during the reset cycle are not accepted.

Optional Feature:
- Macro ALU_SIGNED_SLT_EN.
- Defined: SLT compares a and b as two's-complement signed.
- Undefined: SLT is unsigned, matching the existing processor ALU.
- No other opcode changes.

Test Plan:
- Reset:
  - Stimulus: reset high 2 cycles, then low.
  - Required: out_valid=0, in_ready=1, result=0, zero=1, carry=0, overflow=0.
- ADD overflow/carry, WIDTH=16:
  - Stimulus: ADD a=0x7FFF b=0x0001, out_ready=1.
  - Required: out_valid the next cycle, result=0x8000, overflow=1, carry=0.
  - Then ADD 0xFFFF+0x0001: result=0x0000, zero=1, carry=1, overflow=0.
- MUL timing:
  - Stimulus: MUL a=0x0123 b=0x0045, accepted at cycle T.
  - Required: in_ready=0 for cycles T+1..T+16; out_valid at T+17; result=0x4E6F, carry=0.
  - Then MUL 0x0100*0x0100: result=0x0000, carry=1, zero=1.
- Backpressure and back-to-back:
  - Stimulus: SUB 5-7 with out_ready=0 for 3 cycles.
  - Required: result=0xFFFE, carry=1, held stable, in_ready=0.
  - Raise out_ready with OR 0x00F0|0x000F presented: accepted the same cycle; next cycle result=0x00FF.
- SLT and shifts:
  - Stimulus: SLT a=0xFFFF b=0x0001.
  - Required: result=0 without the macro, 1 with ALU_SIGNED_SLT_EN.
  - SLL 0x0001 by b=0x0013 → 0x0008 (amount 3); SRL 0x8000 by 15 → 0x0001.
- Reset mid-MUL:
  - Stimulus: assert reset 5 cycles after a MUL is accepted.
  - Required: IDLE next cycle, out_valid never rises for that MUL.
  - A following ADD 2+3 returns 5 with 1-cycle latency.
